// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - PC register and branch/jump resolution with halt-on-fault
// and a saturating taken-redirect counter.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_en,
  input  logic             branch_i,
  input  logic             jal_i,
  input  logic             jalr_i,
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       comparador_code,
  input  logic [31:0]      imm_i,
  input  logic [31:0]      rs1_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             taken_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic [1:0]       cause_o,
  input  logic             resume_i,
  output logic [CNT_W-1:0] taken_cnt_o
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state;
  logic        sel_jalr, sel_jal, sel_br;
  logic        br_cond, unsupported, redirect, misaligned, fault;
  logic [31:0] target;

  assign pc_plus4_o = pc_o + 32'd4;
  assign halted_o   = (state == HALT);

  always_comb begin
    sel_jalr    = jalr_i;
    sel_jal     = !jalr_i && jal_i;
    sel_br      = !jalr_i && !jal_i && branch_i;
    target      = sel_jalr ? ((rs1_i + imm_i) & ~32'h1) : (pc_o + imm_i);
    br_cond     = 1'b0;
    unsupported = 1'b0;
    // code 01 = equal, 00 = less-than unsigned; 11 is never a valid comparison
    case (funct3_i)
      3'b000:  br_cond = (comparador_code == 2'b01);
      3'b001:  br_cond = (comparador_code != 2'b01);
      3'b110:  br_cond = (comparador_code == 2'b00);
      3'b111:  br_cond = (comparador_code != 2'b00);
      default: unsupported = sel_br;
    endcase
    if (sel_br && comparador_code == 2'b11)
      unsupported = 1'b1;
    redirect   = sel_jalr || sel_jal || (sel_br && br_cond && !unsupported);
    misaligned = redirect && (target[1:0] != 2'b00);
    fault      = (state == RUN) && (unsupported || misaligned);
    taken_o    = (state == RUN) && redirect && !misaligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc_o        <= RESET_PC;
      flush_o     <= 1'b0;
      cause_o     <= 2'b00;
      taken_cnt_o <= '0;
    end else begin
      flush_o <= 1'b0;
      case (state)
        RUN: begin
          if (pc_en) begin
            if (fault) begin
              state   <= HALT;
              cause_o <= unsupported ? 2'b10 : 2'b01;
            end else if (taken_o) begin
              pc_o    <= target;
              flush_o <= 1'b1;
              if (taken_cnt_o != {CNT_W{1'b1}})
                taken_cnt_o <= taken_cnt_o + CNT_W'(1);
            end else begin
              pc_o <= pc_plus4_o;
            end
          end
        end
        HALT: begin
          if (resume_i) begin
            state   <= RUN;
            pc_o    <= RESET_PC;
            cause_o <= 2'b00;
            flush_o <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - directed bench with a per-cycle reference model for
// branch_pc_unit (two instances: CNT_W=16 and CNT_W=2).
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_en = 1'b0, branch_i = 1'b0, jal_i = 1'b0, jalr_i = 1'b0, resume_i = 1'b0;
  logic [2:0]  funct3_i = 3'b0;
  logic [1:0]  comparador_code = 2'b0;
  logic [31:0] imm_i = 32'h0, rs1_i = 32'h0;

  logic [31:0] pc_o, pc_plus4_o, pc2, pc2_plus4;
  logic        taken_o, flush_o, halted_o, taken2, flush2, halted2;
  logic [1:0]  cause_o, cause2;
  logic [15:0] cnt_o;
  logic [1:0]  cnt2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_pc_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .branch_i(branch_i), .jal_i(jal_i),
    .jalr_i(jalr_i), .funct3_i(funct3_i), .comparador_code(comparador_code),
    .imm_i(imm_i), .rs1_i(rs1_i), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .taken_o(taken_o), .flush_o(flush_o), .halted_o(halted_o), .cause_o(cause_o),
    .resume_i(resume_i), .taken_cnt_o(cnt_o)
  );

  branch_pc_unit #(.RESET_PC(32'h0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .branch_i(branch_i), .jal_i(jal_i),
    .jalr_i(jalr_i), .funct3_i(funct3_i), .comparador_code(comparador_code),
    .imm_i(imm_i), .rs1_i(rs1_i), .pc_o(pc2), .pc_plus4_o(pc2_plus4),
    .taken_o(taken2), .flush_o(flush2), .halted_o(halted2), .cause_o(cause2),
    .resume_i(resume_i), .taken_cnt_o(cnt2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural PC, halted flag, cause, flush and counters.
  logic [31:0] m_pc;
  bit          m_halt, m_flush;
  logic [1:0]  m_cause;
  int          m_cnt, m_cnt2;

  function automatic void resolve(output bit tk, output logic [1:0] flt, output logic [31:0] tgt);
    bit want = 0;
    flt = 2'b00;
    tgt = jalr_i ? ((rs1_i + imm_i) & 32'hFFFF_FFFE) : (m_pc + imm_i);
    if (jalr_i || jal_i) want = 1;
    else if (branch_i) begin
      if (comparador_code == 2'b11) flt = 2'b10;
      else case (funct3_i)
        3'b000: want = (comparador_code == 2'b01);   // BEQ
        3'b001: want = (comparador_code != 2'b01);   // BNE
        3'b110: want = (comparador_code == 2'b00);   // BLTU
        3'b111: want = (comparador_code != 2'b00);   // BGEU
        default: flt = 2'b10;
      endcase
    end
    if (want && (tgt % 4) != 0) flt = 2'b01;
    if (m_halt) flt = 2'b00;
    tk = !m_halt && want && flt == 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit tk; logic [1:0] flt; logic [31:0] tgt;
    if (!rst_n) begin
      m_pc = 32'h0; m_halt = 0; m_flush = 0; m_cause = 2'b00; m_cnt = 0; m_cnt2 = 0;
    end else begin
      resolve(tk, flt, tgt);
      m_flush = 0;
      if (m_halt) begin
        if (resume_i) begin
          m_pc = 32'h0; m_cause = 2'b00; m_halt = 0; m_flush = 1;
        end
      end else if (pc_en) begin
        if (flt != 2'b00) begin
          m_halt = 1; m_cause = flt;
        end else if (tk) begin
          m_pc = tgt; m_flush = 1;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end else m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    bit tk; logic [1:0] flt; logic [31:0] tgt;
    if (rst_n) begin
      resolve(tk, flt, tgt);
      chk("pc", pc_o, m_pc);
      chk("pc_plus4", pc_plus4_o, m_pc + 32'd4);
      chk("taken", taken_o, tk);
      chk("flush", flush_o, m_flush);
      chk("halted", halted_o, m_halt);
      chk("cause", cause_o, m_cause);
      chk("cnt", cnt_o, m_cnt);
      chk("pc_w2", pc2, m_pc);
      chk("taken_w2", taken2, tk);
      chk("flush_w2", flush2, m_flush);
      chk("halted_w2", halted2, m_halt);
      chk("cnt_w2", cnt2, m_cnt2);
    end
  end

  task automatic idle();
    branch_i = 0; jal_i = 0; jalr_i = 0; resume_i = 0; pc_en = 1;
    funct3_i = 3'b000; comparador_code = 2'b00; imm_i = 32'h0; rs1_i = 32'h0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic br(input logic [2:0] f3, input logic [1:0] code, input logic [31:0] imm);
    idle(); branch_i = 1; funct3_i = f3; comparador_code = code; imm_i = imm;
  endtask

  logic [2:0] f3s [4] = '{3'b000, 3'b001, 3'b110, 3'b111};

  initial begin
    idle();
    #12 rst_n = 1;
    #1;
    chk("reset_pc", pc_o, 32'h0);
    chk("reset_flush", flush_o, 1'b0);
    chk("reset_halted", halted_o, 1'b0);
    chk("reset_cnt", cnt_o, 16'h0);
    @(posedge clk); #1;
    chk("seq_pc1", pc_o, 32'h4);
    step(); chk("seq_pc2", pc_o, 32'h8);
    step(); chk("seq_pc3", pc_o, 32'hC);
    chk("seq_flush", flush_o, 1'b0);
    for (int i = 0; i < 61; i++) step();
    chk("pc_0x100", pc_o, 32'h100);

    br(3'b000, 2'b01, 32'h40); #1;
    chk("beq_taken", taken_o, 1'b1);
    step(); idle();
    chk("beq_pc", pc_o, 32'h140);
    chk("beq_flush", flush_o, 1'b1);
    chk("beq_cnt", cnt_o, 16'd1);
    step();
    chk("beq_flush_drop", flush_o, 1'b0);
    br(3'b000, 2'b10, 32'h40); #1;
    chk("beq_not_taken", taken_o, 1'b0);
    step(); idle();
    chk("beq_nt_pc", pc_o, 32'h148);

    idle(); jalr_i = 1; jal_i = 1; rs1_i = 32'h2001; imm_i = 32'h3;
    step(); idle();
    chk("jalr_pc", pc_o, 32'h2004);

    idle(); jal_i = 1; imm_i = 32'hFFFF_E00C;
    step();
    chk("jal_back_pc", pc_o, 32'h10);
    jal_i = 1; imm_i = 32'h6; #1;
    chk("mis_taken", taken_o, 1'b0);
    step();
    chk("mis_halted", halted_o, 1'b1);
    chk("mis_cause", cause_o, 2'b01);
    chk("mis_pc", pc_o, 32'h10);
    imm_i = 32'h4; step();
    chk("halt_hold_pc", pc_o, 32'h10);
    idle(); pc_en = 0; resume_i = 1; step(); idle();
    chk("resume_pc", pc_o, 32'h0);
    chk("resume_cause", cause_o, 2'b00);
    chk("resume_flush", flush_o, 1'b1);
    chk("resume_cnt", cnt_o, 16'd3);

    br(3'b100, 2'b01, 32'h8); step(); idle();
    chk("unsup_cause", cause_o, 2'b10);
    resume_i = 1; step(); idle();
    br(3'b000, 2'b11, 32'h8); step(); idle();
    chk("code11_cause", cause_o, 2'b10);
    resume_i = 1; step(); idle();
    jalr_i = 1; rs1_i = 32'h2; step(); idle();
    chk("jalr_mis_cause", cause_o, 2'b01);
    resume_i = 1; step(); idle();

    jal_i = 1; imm_i = 32'h20; step();
    br(3'b000, 2'b01, 32'h40); pc_en = 0; #1;
    chk("stall_taken", taken_o, 1'b1);
    step(); idle();
    chk("stall_pc", pc_o, 32'h20);
    chk("stall_cnt", cnt_o, 16'd4);
    chk("stall_flush", flush_o, 1'b0);

    for (int i = 0; i < 5; i++) begin
      br(3'b001, 2'b10, 32'h4); step();
    end
    chk("bne_cnt2_sat", cnt2, 2'd3);
    chk("bne_cnt", cnt_o, 16'd9);
    chk("bne_pc", pc_o, 32'h34);

    foreach (f3s[k])
      for (int c = 0; c < 3; c++) begin
        br(f3s[k], 2'(c), 32'h8); step();
      end
    idle(); step();

    br(3'b001, 2'b10, 32'h4); step();
    #2 rst_n = 0; #1;
    chk("async_pc", pc_o, 32'h0);
    chk("async_flush", flush_o, 1'b0);
    chk("async_halted", halted_o, 1'b0);
    chk("async_cause", cause_o, 2'b00);
    chk("async_cnt", cnt_o, 16'h0);
    chk("async_cnt2", cnt2, 2'd0);
    idle(); #4 rst_n = 1;
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
